// File: rtl/ex_div_seq_pkg.sv
// rtl/ex_div_seq_pkg.sv - shared encodings and helpers for the EX-stage divide sequencer
package ex_div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // DIV and REM are the signed flavours; bit 0 of the op code marks unsigned
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder instead of the quotient
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/ex_div_seq_if.sv
// rtl/ex_div_seq_if.sv - EX-stage to divide sequencer request/response bundle
interface ex_div_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            cancel;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic            busy;
    logic            stallreq;

    modport master (
        output start, op, dividend, divisor, cancel,
        input  result, result_valid, busy, stallreq
    );

    modport slave (
        input  start, op, dividend, divisor, cancel,
        output result, result_valid, busy, stallreq
    );
endinterface

// File: rtl/ex_div_seq.sv
// rtl/ex_div_seq.sv - radix-2 restoring divide sequencer for RV32M DIV/DIVU/REM/REMU
module ex_div_seq
    import ex_div_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic         clk,
    input logic         rst,
    ex_div_seq_if.slave bus
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    div_state_e       state;
    logic             rem_sel;
    logic             neg_q;
    logic             neg_r;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  dsor;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  result_r;
    logic             valid_r;

    // Operand preparation for a new request
    logic            sgn;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] special_res;

    assign sgn      = op_is_signed(bus.op);
    assign a_neg    = sgn & bus.dividend[XLEN-1];
    assign b_neg    = sgn & bus.divisor[XLEN-1];
    assign a_abs    = cond_neg(a_neg, bus.dividend);
    assign b_abs    = cond_neg(b_neg, bus.divisor);
    assign div_zero = (bus.divisor == '0);
    assign ovf      = sgn && (bus.dividend == MIN_NEG) && (bus.divisor == '1);

    // Divide by zero: q = all ones, r = dividend. Overflow: q = dividend (MIN_NEG), r = 0.
    assign special_res = div_zero ? (op_is_rem(bus.op) ? bus.dividend : '1)
                                  : (op_is_rem(bus.op) ? '0 : bus.dividend);

    // One restoring step: quo doubles as the dividend shifter and the quotient collector
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] diff;
    logic            borrow;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic            unused_diff_bit;

    assign rem_sh          = {rem, quo[XLEN-1]};
    assign diff            = {1'b0, rem_sh} - {2'b00, dsor};
    assign borrow          = diff[XLEN+1];
    assign rem_nx          = borrow ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_nx          = {quo[XLEN-2:0], ~borrow};
    assign unused_diff_bit = diff[XLEN];

    // Sequencer: accept, iterate, fix up signs and present the result for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DIV_IDLE;
            rem_sel  <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            dsor     <= '0;
            cnt      <= '0;
            result_r <= '0;
            valid_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (bus.cancel) begin
                state <= DIV_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    DIV_IDLE: begin
                        if (bus.start) begin
                            rem_sel <= op_is_rem(bus.op);
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            quo     <= a_abs;
                            rem     <= '0;
                            dsor    <= b_abs;
                            cnt     <= '0;
                            if (div_zero || ovf) begin
                                result_r <= special_res;
                                valid_r  <= 1'b1;
                                state    <= DIV_DONE;
                            end else begin
                                state <= DIV_BUSY;
                            end
                        end
                    end
                    DIV_BUSY: begin
                        quo <= quo_nx;
                        rem <= rem_nx;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            result_r <= rem_sel ? cond_neg(neg_r, rem_nx) : cond_neg(neg_q, quo_nx);
                            valid_r  <= 1'b1;
                            state    <= DIV_DONE;
                        end
                    end
                    DIV_DONE: state <= DIV_IDLE;
                    default:  state <= DIV_IDLE;
                endcase
            end
        end
    end

    assign bus.result       = result_r;
    assign bus.result_valid = valid_r;
    assign bus.busy         = (state != DIV_IDLE);
    assign bus.stallreq     = ((state == DIV_IDLE) && bus.start && !bus.cancel) || (state == DIV_BUSY);

endmodule

// File: tb/tb_ex_div_seq.sv
// tb/tb_ex_div_seq.sv - randomized self-checking bench for ex_div_seq
module tb_ex_div_seq;
    import ex_div_seq_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_div_seq_if #(.XLEN(XLEN)) dif();

    ex_div_seq #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // RV32M semantics computed straight from the arithmetic rules
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            DIV_OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            DIV_OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            DIV_OP_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default:     return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Cycle-level model: 0 idle, 1 busy, 2 done
    int          m_st   = 0;
    int          m_left = 0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_st  = 0;
            m_res = '0;
        end else if (dif.cancel) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: if (dif.start) begin
                    if (is_fast(dif.op, dif.dividend, dif.divisor)) begin
                        m_res = ref_div(dif.op, dif.dividend, dif.divisor);
                        m_st  = 2;
                    end else begin
                        m_pend = ref_div(dif.op, dif.dividend, dif.divisor);
                        m_left = XLEN;
                        m_st   = 1;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_st  = 2;
                        m_res = m_pend;
                    end
                end
                default: m_st = 0;
            endcase
        end
    end

    // Compare every cycle once reset has been applied
    always @(negedge clk) begin
        if (chk_on) begin
            chk("result", dif.result, m_res);
            chk("result_valid", 32'(dif.result_valid), 32'(m_st == 2));
            chk("busy", 32'(dif.busy), 32'(m_st != 0));
            chk("stallreq", 32'(dif.stallreq),
                32'(((m_st == 0) && dif.start && !dif.cancel) || (m_st == 1)));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Issue one op in the current cycle and measure latency and stall length
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int n;
        int stalls;
        bit seen;
        next_cycle();
        dif.start = 1'b1; dif.op = o; dif.dividend = a; dif.divisor = b; dif.cancel = 1'b0;
        n = 0; stalls = 0; seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (dif.result_valid) seen = 1'b1;
            else begin
                if (dif.stallreq) stalls++;
                n++;
            end
        end
        chk("op_seen", 32'(seen), 32'd1);
        chk("op_latency", 32'(n), 32'(lat));
        chk("op_stall_cycles", 32'(stalls), 32'(lat));
        chk("op_result", dif.result, exp);
        chk("op_stall_in_done", 32'(dif.stallreq), 32'd0);
    endtask

    logic [1:0]  t_op  [8] = '{DIV_OP_DIV, DIV_OP_REM, DIV_OP_DIVU, DIV_OP_DIV, DIV_OP_REMU,
                              DIV_OP_DIV, DIV_OP_REM, DIV_OP_DIVU};
    logic [31:0] t_a   [8] = '{32'd100, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'd5, 32'd5,
                              32'h8000_0000, 32'h8000_0000, 32'd1000};
    logic [31:0] t_b   [8] = '{32'd7, 32'd7, 32'd2, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
    logic [31:0] t_exp [8] = '{32'd14, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                              32'h8000_0000, 32'd0, 32'd333};
    int          t_lat [8] = '{33, 33, 33, 1, 1, 1, 1, 33};

    initial begin
        int n;
        int vcount;
        bit fin;
        int gap;
        int r;
        int sel;

        rst = 1'b1;
        dif.start = 1'b0; dif.op = 2'b00; dif.dividend = '0; dif.divisor = '0; dif.cancel = 1'b0;

        // Pin the reference model against hand-computed values
        chk("model_div", ref_div(DIV_OP_DIV, 32'd100, 32'd7), 32'd14);
        chk("model_rem_neg", ref_div(DIV_OP_REM, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFFE);
        chk("model_div_neg", ref_div(DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFF2);
        chk("model_remu_zero", ref_div(DIV_OP_REMU, 32'd5, 32'd0), 32'd5);
        chk("model_div_ovf", ref_div(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        next_cycle();
        next_cycle();
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_result", dif.result, 32'd0);
        chk("rst_valid", 32'(dif.result_valid), 32'd0);
        chk("rst_busy", 32'(dif.busy), 32'd0);
        chk("rst_stallreq", 32'(dif.stallreq), 32'd0);
        rst = 1'b0;

        // Directed table, issued back to back at the minimum interval
        for (int i = 0; i < 8; i++) run_op(t_op[i], t_a[i], t_b[i], t_exp[i], t_lat[i]);

        // Cancel at T+10, fresh start at T+11 completing at T+44
        next_cycle();
        dif.start = 1'b1; dif.op = DIV_OP_DIV; dif.dividend = 32'd100; dif.divisor = 32'd7;
        vcount = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (dif.result_valid) vcount++;
            next_cycle();
        end
        dif.cancel = 1'b1;
        @(negedge clk);
        if (dif.result_valid) vcount++;
        next_cycle();
        dif.cancel = 1'b0; dif.op = DIV_OP_DIVU; dif.dividend = 32'd1000; dif.divisor = 32'd7;
        @(negedge clk);
        chk("cancel_busy", 32'(dif.busy), 32'd0);
        chk("cancel_valid", 32'(dif.result_valid), 32'd0);
        chk("cancel_result_kept", dif.result, 32'd333);
        chk("cancel_no_valid", 32'(vcount), 32'd0);
        n = 0; fin = 1'b0;
        for (int k = 0; k < 60 && !fin; k++) begin
            @(negedge clk);
            n++;
            if (dif.result_valid) fin = 1'b1;
        end
        chk("cancel_restart_latency", 32'(n), 32'd33);
        chk("cancel_restart_result", dif.result, 32'd142);

        // Reset at T+5 in the middle of an operation
        next_cycle();
        dif.op = DIV_OP_DIV; dif.dividend = 32'd100; dif.divisor = 32'd7;
        repeat (5) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; dif.start = 1'b0;
        @(negedge clk);
        chk("midrst_result", dif.result, 32'd0);
        chk("midrst_valid", 32'(dif.result_valid), 32'd0);
        chk("midrst_busy", 32'(dif.busy), 32'd0);
        chk("midrst_stallreq", 32'(dif.stallreq), 32'd0);
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dif.result_valid) vcount++;
        end
        chk("midrst_no_valid", 32'(vcount), 32'd0);

        // Randomized traffic with occasional cancel and reset
        for (int i = 0; i < 300; i++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                next_cycle();
                dif.start = 1'b0;
            end
            next_cycle();
            sel = int'($urandom_range(0, 7));
            dif.op = 2'($urandom_range(0, 3));
            dif.dividend = $urandom;
            dif.divisor = $urandom;
            case (sel)
                0: dif.divisor = '0;
                1: begin dif.dividend = 32'h8000_0000; dif.divisor = 32'hFFFF_FFFF; end
                2: begin
                    dif.dividend = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(0, 63)) : 32'($urandom_range(0, 63));
                    dif.divisor  = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 15)) : 32'($urandom_range(1, 15));
                end
                3: dif.divisor = ($urandom_range(0, 1) != 0) ? 32'd1 : 32'hFFFF_FFFF;
                4: dif.divisor = dif.divisor >> $urandom_range(0, 31);
                default: ;
            endcase
            dif.start = 1'b1; dif.cancel = 1'b0;
            fin = 1'b0;
            for (int k = 0; k < 60 && !fin; k++) begin
                @(negedge clk);
                if (dif.result_valid) fin = 1'b1;
                else begin
                    next_cycle();
                    r = int'($urandom_range(0, 199));
                    if (r < 3) begin
                        dif.cancel = 1'b1;
                        next_cycle();
                        dif.cancel = 1'b0; dif.start = 1'b0;
                        fin = 1'b1;
                    end else if (r == 3) begin
                        rst = 1'b1;
                        next_cycle();
                        rst = 1'b0; dif.start = 1'b0;
                        fin = 1'b1;
                    end
                end
            end
            chk("rand_op_bound", 32'(fin), 32'd1);
        end

        next_cycle();
        dif.start = 1'b0;
        repeat (3) next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
